// File: rtl/fpcmp_pkg.sv
// Shared types and constants for the slab-test comparator arbiter: operand
// format (FloPoCo 2-bit exception, sign, 11-bit exponent, 2-bit fraction) and the request tag.
package fpcmp_pkg;

    localparam int OPERAND_W = 16;
    localparam int EXP_W     = 11;
    localparam int FRAC_W    = 2;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } fp_exc_e;

    // Index field is sized for the largest supported requester count (8).
    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] index;
    } tag_t;

    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fpcmp_arbiter_rr.sv
// Grant logic for the comparator arbiter: round-robin from ptr+1 when
// CMPARB_ROUND_ROBIN_EN is defined, lowest-index fixed priority otherwise.
module rr_arbiter
    import fpcmp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = tag_w(NREQ)
)(
    input  logic [NREQ-1:0]  req,
`ifdef CMPARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;

`ifdef CMPARB_ROUND_ROBIN_EN
    int cand;

    // Walk the ring starting just after the last winner; first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/fpcmp_arbiter.sv
// Shares one pipelined FP less-or-equal comparator among NREQ slab units and
// routes each result back to its issuer. CMPARB_ROUND_ROBIN_EN selects round-robin.
module fpcmp_arbiter
    import fpcmp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = OPERAND_W - 1,
    parameter int CMP_LAT = 3
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0]    req_a,
    input  logic [NREQ*(WIDTH+1)-1:0]    req_b,
    input  logic                         flush,
    output logic [WIDTH:0]               cmp_a,
    output logic [WIDTH:0]               cmp_b,
    input  logic                         cmp_le,
    output logic [NREQ-1:0]              rsp_valid,
    output logic                         rsp_le,
    output logic [$clog2(CMP_LAT+2)-1:0] inflight
);

    localparam int OPW   = WIDTH + 1;
    localparam int IDX_W = tag_w(NREQ);
    localparam int CNT_W = $clog2(CMP_LAT + 2);

    logic [OPW-1:0]   op_a [NREQ];
    logic [OPW-1:0]   op_b [NREQ];
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             xfer;

    logic [OPW-1:0]   cmp_a_reg;
    logic [OPW-1:0]   cmp_b_reg;
    logic [NREQ-1:0]  rsp_valid_reg;
    logic             rsp_le_reg;
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;
    logic [NREQ-1:0]  rsp_hit;

    // Stage 0 travels alongside cmp_a/cmp_b; stages 1..CMP_LAT track the
    // comparator's own latency so the last stage lines up with cmp_le.
    tag_t             tag_pipe_reg [CMP_LAT+1];
    tag_t             issue_tag;
    tag_t             tag_out;

`ifdef CMPARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi]    = req_a[gi*OPW +: OPW];
            assign op_b[gi]    = req_b[gi*OPW +: OPW];
            assign rsp_hit[gi] = tag_out.valid && (tag_out.index == TAG_IDX_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .NREQ      (NREQ),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req       (req_valid),
`ifdef CMPARB_ROUND_ROBIN_EN
        .ptr       (ptr_reg),
`endif
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is suppressed during flush and reset so nothing is accepted that
    // would immediately be discarded.
    assign req_ready = (rst || flush) ? '0 : grant;
    assign xfer      = |req_ready;

    assign issue_tag.valid = xfer;
    assign issue_tag.index = TAG_IDX_W'(grant_idx);
    assign tag_out         = tag_pipe_reg[CMP_LAT];

    always_comb begin
        inflight_next = inflight_reg;
        if (xfer && !tag_out.valid) begin
            inflight_next = inflight_reg + CNT_W'(1);
        end else if (!xfer && tag_out.valid) begin
            inflight_next = inflight_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_a_reg     <= '0;
            cmp_b_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_le_reg    <= 1'b0;
            inflight_reg  <= '0;
            for (int k = 0; k <= CMP_LAT; k++) begin
                tag_pipe_reg[k] <= '0;
            end
`ifdef CMPARB_ROUND_ROBIN_EN
            ptr_reg       <= IDX_W'(NREQ - 1);
`endif
        end else begin
            if (xfer) begin
                cmp_a_reg <= op_a[grant_idx];
                cmp_b_reg <= op_b[grant_idx];
`ifdef CMPARB_ROUND_ROBIN_EN
                ptr_reg   <= grant_idx;
`endif
            end
            if (flush) begin
                for (int k = 0; k <= CMP_LAT; k++) begin
                    tag_pipe_reg[k] <= '0;
                end
                rsp_valid_reg <= '0;
                rsp_le_reg    <= 1'b0;
                inflight_reg  <= '0;
            end else begin
                tag_pipe_reg[0] <= issue_tag;
                for (int k = 1; k <= CMP_LAT; k++) begin
                    tag_pipe_reg[k] <= tag_pipe_reg[k-1];
                end
                rsp_valid_reg <= rsp_hit;
                rsp_le_reg    <= tag_out.valid & cmp_le;
                inflight_reg  <= inflight_next;
            end
        end
    end

    assign cmp_a     = cmp_a_reg;
    assign cmp_b     = cmp_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_le    = rsp_le_reg;
    assign inflight  = inflight_reg;

endmodule
